// File: rtl/rd_req_rr_arbiter.sv
// rtl/rd_req_rr_arbiter.sv - round-robin read-request arbiter with outstanding-credit limit
// Optional per-source grant and backpressure counters enabled by defining ARB_STATS_EN.
module rd_req_rr_arbiter #(
    parameter int N_REQ           = 4,
    parameter int VADDR_BITS      = 48,
    parameter int LEN_BITS        = 28,
    parameter int MAX_OUTSTANDING = 16,
    localparam int SRC_W          = $clog2(N_REQ),
    localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          arb_en,
    input  logic [N_REQ-1:0]              s_valid,
    output logic [N_REQ-1:0]              s_ready,
    input  logic [N_REQ*VADDR_BITS-1:0]   s_vaddr,
    input  logic [N_REQ*LEN_BITS-1:0]     s_len,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [VADDR_BITS-1:0]         m_vaddr,
    output logic [LEN_BITS-1:0]           m_len,
    output logic [SRC_W-1:0]              m_src,
    input  logic                          cpl_valid,
    output logic [OUT_W-1:0]              outstanding,
    output logic                          cpl_underflow
`ifdef ARB_STATS_EN
    ,
    output logic [N_REQ*32-1:0]           grant_cnt,
    output logic [31:0]                   stall_cnt
`endif
);

    localparam logic [OUT_W-1:0] MAX_CNT  = OUT_W'(MAX_OUTSTANDING);
    localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(N_REQ - 1);

    logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  m_valid_q, m_valid_d;
    logic [VADDR_BITS-1:0] m_vaddr_q, m_vaddr_d;
    logic [LEN_BITS-1:0]   m_len_q, m_len_d;
    logic [SRC_W-1:0]      m_src_q, m_src_d;
    logic [OUT_W-1:0]      outstanding_q, outstanding_d;
    logic                  underflow_q, underflow_d;

    logic                  found;
    logic [SRC_W-1:0]      winner;
    logic [VADDR_BITS-1:0] sel_vaddr;
    logic [LEN_BITS-1:0]   sel_len;
    int                    scan_idx;
    logic                  out_free;
    logic                  grant;

    // Rotating priority scan: first valid source at or above rr_ptr, wrapping.
    always_comb begin
        found     = 1'b0;
        winner    = '0;
        sel_vaddr = '0;
        sel_len   = '0;
        scan_idx  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_idx = int'(rr_ptr_q) + i;
            if (scan_idx >= N_REQ) begin
                scan_idx = scan_idx - N_REQ;
            end
            if (!found && s_valid[scan_idx]) begin
                found     = 1'b1;
                winner    = SRC_W'(scan_idx);
                sel_vaddr = s_vaddr[scan_idx*VADDR_BITS +: VADDR_BITS];
                sel_len   = s_len[scan_idx*LEN_BITS +: LEN_BITS];
            end
        end
    end

    assign out_free = !m_valid_q || m_ready;
    assign grant    = aresetn && arb_en && out_free && (outstanding_q < MAX_CNT) && found;
    assign s_ready  = grant ? (N_REQ'(1) << winner) : '0;

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        m_valid_d     = m_valid_q;
        m_vaddr_d     = m_vaddr_q;
        m_len_d       = m_len_q;
        m_src_d       = m_src_q;
        outstanding_d = outstanding_q;
        underflow_d   = underflow_q;
        if (grant) begin
            m_valid_d = 1'b1;
            m_vaddr_d = sel_vaddr;
            m_len_d   = sel_len;
            m_src_d   = winner;
            rr_ptr_d  = (winner == LAST_SRC) ? '0 : winner + SRC_W'(1);
        end else if (out_free) begin
            m_valid_d = 1'b0;
        end
        // A completion arriving with zero credits in use is an error, unless a grant covers it.
        case ({grant, cpl_valid})
            2'b10: outstanding_d = outstanding_q + OUT_W'(1);
            2'b01: begin
                if (outstanding_q == '0) begin
                    underflow_d = 1'b1;
                end else begin
                    outstanding_d = outstanding_q - OUT_W'(1);
                end
            end
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rr_ptr_q      <= '0;
            m_valid_q     <= 1'b0;
            m_vaddr_q     <= '0;
            m_len_q       <= '0;
            m_src_q       <= '0;
            outstanding_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            m_valid_q     <= m_valid_d;
            m_vaddr_q     <= m_vaddr_d;
            m_len_q       <= m_len_d;
            m_src_q       <= m_src_d;
            outstanding_q <= outstanding_d;
            underflow_q   <= underflow_d;
        end
    end

    assign m_valid       = m_valid_q;
    assign m_vaddr       = m_vaddr_q;
    assign m_len         = m_len_q;
    assign m_src         = m_src_q;
    assign outstanding   = outstanding_q;
    assign cpl_underflow = underflow_q;

`ifdef ARB_STATS_EN
    logic [31:0] grant_cnt_q [N_REQ];
    logic [31:0] stall_cnt_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < N_REQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (s_ready[i]) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
                end
            end
            if (m_valid_q && !m_ready) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_grant_cnt
        assign grant_cnt[g*32 +: 32] = grant_cnt_q[g];
    end
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rd_req_rr_arbiter.sv
// tb/tb_rd_req_rr_arbiter.sv - self-checking bench for rd_req_rr_arbiter
module tb_rd_req_rr_arbiter;

    localparam int N    = 4;
    localparam int VA   = 48;
    localparam int LB   = 28;
    localparam int MAXO = 4;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic            arb_en;
    logic [N-1:0]    s_valid;
    logic [N-1:0]    s_ready;
    logic [N*VA-1:0] s_vaddr;
    logic [N*LB-1:0] s_len;
    logic            m_valid;
    logic            m_ready;
    logic [VA-1:0]   m_vaddr;
    logic [LB-1:0]   m_len;
    logic [1:0]      m_src;
    logic            cpl_valid;
    logic [2:0]      outstanding;
    logic            cpl_underflow;
`ifdef ARB_STATS_EN
    logic [N*32-1:0] grant_cnt;
    logic [31:0]     stall_cnt;
`endif

    rd_req_rr_arbiter #(
        .N_REQ(N), .VADDR_BITS(VA), .LEN_BITS(LB), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .arb_en(arb_en),
        .s_valid(s_valid), .s_ready(s_ready), .s_vaddr(s_vaddr), .s_len(s_len),
        .m_valid(m_valid), .m_ready(m_ready), .m_vaddr(m_vaddr), .m_len(m_len),
        .m_src(m_src), .cpl_valid(cpl_valid), .outstanding(outstanding),
        .cpl_underflow(cpl_underflow)
`ifdef ARB_STATS_EN
        , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 aclk = ~aclk;

    logic [VA-1:0] sv_a [N];
    logic [LB-1:0] sv_l [N];
    logic [N-1:0]  keep_valid;

    always_comb begin
        s_vaddr = '0;
        s_len   = '0;
        for (int i = 0; i < N; i++) begin
            s_vaddr[i*VA +: VA] = sv_a[i];
            s_len[i*LB +: LB]   = sv_l[i];
        end
    end

    // Reference model state
    int            rr, outst, msrc_m, scnt;
    bit            mv_m, uf_m;
    logic [VA-1:0] mva_m;
    logic [LB-1:0] mlen_m;
    int            gcnt [N];

    int            tests, fails, grants;
    int            gseq [$];
    logic [N-1:0]  ready_seen;

    function automatic void reset_model();
        rr = 0; outst = 0; msrc_m = 0; scnt = 0;
        mv_m = 0; uf_m = 0; mva_m = '0; mlen_m = '0;
        for (int i = 0; i < N; i++) gcnt[i] = 0;
    endfunction

    function automatic void new_data(int i);
        sv_a[i] = VA'({$urandom(), $urandom()});
        sv_l[i] = LB'($urandom());
    endfunction

    task automatic cycle();
        int win;
        bit free, stall;
        logic [N-1:0] exp_rdy;
        #1;
        win   = -1;
        free  = !mv_m || m_ready;
        stall = mv_m && !m_ready;
        if (aresetn && arb_en && free && outst < MAXO)
            for (int k = 0; k < N; k++)
                if (win < 0 && s_valid[(rr + k) % N]) win = (rr + k) % N;
        exp_rdy = (win >= 0) ? (N'(1) << win) : '0;
        ready_seen |= s_ready;
        tests++;
        if (s_ready !== exp_rdy) begin
            fails++; $display("FAIL s_ready: got %b expected %b", s_ready, exp_rdy);
        end
        tests++;
        if (m_valid !== mv_m || m_vaddr !== mva_m || m_len !== mlen_m || m_src !== 2'(msrc_m)) begin
            fails++;
            $display("FAIL m_out: got v=%b a=%h l=%h s=%0d expected v=%b a=%h l=%h s=%0d",
                     m_valid, m_vaddr, m_len, m_src, mv_m, mva_m, mlen_m, msrc_m);
        end
        tests++;
        if (outstanding !== 3'(outst) || cpl_underflow !== uf_m) begin
            fails++;
            $display("FAIL credits: got out=%0d uf=%b expected out=%0d uf=%b",
                     outstanding, cpl_underflow, outst, uf_m);
        end
`ifdef ARB_STATS_EN
        tests++;
        if (stall_cnt !== 32'(scnt)) begin
            fails++; $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, scnt);
        end
        for (int i = 0; i < N; i++) begin
            tests++;
            if (grant_cnt[i*32 +: 32] !== 32'(gcnt[i])) begin
                fails++;
                $display("FAIL grant_cnt%0d: got %0d expected %0d", i, grant_cnt[i*32 +: 32], gcnt[i]);
            end
        end
`endif
        @(posedge aclk);
        @(negedge aclk);
        if (!aresetn) begin
            reset_model();
        end else begin
            if (stall) scnt++;
            if (win >= 0) begin
                grants++;
                gseq.push_back(win);
                gcnt[win]++;
                mv_m = 1; mva_m = sv_a[win]; mlen_m = sv_l[win]; msrc_m = win;
                rr = (win + 1) % N;
            end else if (free) begin
                mv_m = 0;
            end
            if (win >= 0 && !cpl_valid) outst++;
            else if (win < 0 && cpl_valid) begin
                if (outst == 0) uf_m = 1;
                else outst--;
            end
            if (win >= 0) begin
                s_valid[win] = keep_valid[win];
                new_data(win);
            end
        end
    endtask

    task automatic do_reset();
        aresetn = 0; cycle(); aresetn = 1;
    endtask

    task automatic test_reset();
        aresetn = 0; arb_en = 1; m_ready = 1; s_valid = '1;
        cycle();
        tests++;
        if (m_valid !== 1'b0 || m_vaddr !== '0 || m_len !== '0 || m_src !== '0) begin
            fails++; $display("FAIL reset_m: got v=%b a=%h l=%h s=%0d expected zeros", m_valid, m_vaddr, m_len, m_src);
        end
        tests++;
        if (outstanding !== 3'd0 || cpl_underflow !== 1'b0 || s_ready !== '0) begin
            fails++; $display("FAIL reset_cnt: got out=%0d uf=%b rdy=%b expected 0 0 0", outstanding, cpl_underflow, s_ready);
        end
        aresetn = 1; s_valid = '0;
        cycle();
    endtask

    task automatic test_rr_all();
        s_valid = '1; keep_valid = '1; m_ready = 1; cpl_valid = 0;
        gseq.delete();
        cycle();
        cpl_valid = 1;
        repeat (8) cycle();
        for (int i = 0; i < 9; i++) begin
            tests++;
            if (i >= gseq.size() || gseq[i] != i % N) begin
                fails++; $display("FAIL rr_all_seq%0d: got %0d expected %0d", i, (i < gseq.size()) ? gseq[i] : -1, i % N);
            end
        end
        tests++;
        if (outstanding !== 3'd1) begin
            fails++; $display("FAIL rr_all_out: got %0d expected 1", outstanding);
        end
        s_valid = '0; cycle(); cpl_valid = 0; cycle();
    endtask

    task automatic test_pair();
        s_valid = 4'b1010; keep_valid = 4'b1010; cpl_valid = 1; ready_seen = '0;
        gseq.delete();
        repeat (8) cycle();
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (i >= gseq.size() || gseq[i] != ((i % 2) ? 3 : 1)) begin
                fails++; $display("FAIL pair_seq%0d: got %0d expected %0d", i, (i < gseq.size()) ? gseq[i] : -1, (i % 2) ? 3 : 1);
            end
        end
        tests++;
        if (ready_seen[0] !== 1'b0 || ready_seen[2] !== 1'b0) begin
            fails++; $display("FAIL pair_idle: got ready_seen=%b expected bits 0,2 clear", ready_seen);
        end
        s_valid = '0; cpl_valid = 0; cycle();
    endtask

    task automatic test_credit();
        int g0;
        s_valid = '1; keep_valid = '1; cpl_valid = 0; grants = 0;
        repeat (8) cycle();
        #1;
        tests++;
        if (grants != 4 || outstanding !== 3'd4 || s_ready !== '0) begin
            fails++; $display("FAIL credit_cap: got grants=%0d out=%0d rdy=%b expected 4 4 0000", grants, outstanding, s_ready);
        end
        g0 = grants;
        cpl_valid = 1; cycle(); cpl_valid = 0;
        tests++;
        if (grants != g0) begin
            fails++; $display("FAIL credit_pulse_cycle: got %0d grants expected %0d", grants, g0);
        end
        cycle();
        tests++;
        if (grants != g0 + 1) begin
            fails++; $display("FAIL credit_resume: got %0d grants expected %0d", grants, g0 + 1);
        end
        repeat (4) cycle();
        tests++;
        if (grants != g0 + 1) begin
            fails++; $display("FAIL credit_single: got %0d grants expected %0d", grants, g0 + 1);
        end
        s_valid = '0; cpl_valid = 1; repeat (4) cycle(); cpl_valid = 0; cycle();
    endtask

    task automatic test_backpressure();
        int g0;
        logic [VA-1:0] held;
        s_valid = 4'b0100; keep_valid = 4'b0100; m_ready = 1; cpl_valid = 0;
        cycle();
        held = mva_m;
        m_ready = 0;
        repeat (5) cycle();
        tests++;
        if (m_valid !== 1'b1 || m_vaddr !== held || m_src !== 2'd2) begin
            fails++; $display("FAIL bp_hold: got v=%b a=%h s=%0d expected 1 %h 2", m_valid, m_vaddr, m_src, held);
        end
        m_ready = 1; g0 = grants;
        cycle();
        tests++;
        if (grants != g0 + 1) begin
            fails++; $display("FAIL bp_resume: got %0d grants expected %0d", grants, g0 + 1);
        end
        s_valid = '0; cpl_valid = 1; repeat (2) cycle(); cpl_valid = 0; cycle();
    endtask

    task automatic test_underflow();
        s_valid = '0; m_ready = 1; cpl_valid = 1;
        cycle();
        cpl_valid = 0;
        repeat (3) cycle();
        tests++;
        if (cpl_underflow !== 1'b1 || outstanding !== 3'd0) begin
            fails++; $display("FAIL uf_sticky: got uf=%b out=%0d expected 1 0", cpl_underflow, outstanding);
        end
        s_valid = '1; keep_valid = '1; m_ready = 0;
        repeat (2) cycle();
        do_reset();
        s_valid = '0; m_ready = 1;
        tests++;
        if (m_valid !== 1'b0 || m_vaddr !== '0 || m_len !== '0 || m_src !== '0 ||
            outstanding !== 3'd0 || cpl_underflow !== 1'b0) begin
            fails++;
            $display("FAIL midreset: got v=%b a=%h l=%h s=%0d out=%0d uf=%b expected all zero",
                     m_valid, m_vaddr, m_len, m_src, outstanding, cpl_underflow);
        end
        cpl_valid = 1; cycle(); cpl_valid = 0; cycle();
        tests++;
        if (cpl_underflow !== 1'b1) begin
            fails++; $display("FAIL uf_after_reset: got %b expected 1", cpl_underflow);
        end
        do_reset();
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        s_valid = 4'b0001; keep_valid = 4'b0001; m_ready = 1; cpl_valid = 1;
        repeat (10) cycle();
        s_valid = '0; cpl_valid = 0; m_ready = 0;
        repeat (3) cycle();
        m_ready = 1; cycle();
        tests++;
        if (grant_cnt[31:0] !== 32'd10 || stall_cnt !== 32'd3) begin
            fails++; $display("FAIL stats: got grant0=%0d stall=%0d expected 10 3", grant_cnt[31:0], stall_cnt);
        end
        do_reset();
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            aresetn    = ($urandom_range(0, 199) != 0);
            arb_en     = ($urandom_range(0, 9) != 0);
            m_ready    = ($urandom_range(0, 3) != 0);
            cpl_valid  = ($urandom_range(0, 2) == 0);
            keep_valid = N'($urandom());
            for (int i = 0; i < N; i++)
                if (!s_valid[i] && $urandom_range(0, 1) == 1) begin
                    s_valid[i] = 1'b1;
                    new_data(i);
                end
            cycle();
        end
        aresetn = 1;
    endtask

    initial begin
        tests = 0; fails = 0; grants = 0; ready_seen = '0;
        aresetn = 0; arb_en = 1; m_ready = 1; cpl_valid = 0; s_valid = '0; keep_valid = '1;
        for (int i = 0; i < N; i++) new_data(i);
        reset_model();
        @(negedge aclk);
        test_reset();
        test_rr_all();
        test_pair();
        test_credit();
        test_backpressure();
        test_underflow();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rd_req_rr_arbiter.md
# rd_req_rr_arbiter

Round-robin arbiter that shares one user read-request port between `N_REQ` independent request generators (random/stride traffic engines). Each generator presents a valid/ready request stream; the arbiter picks one per cycle, registers it onto the single downstream request interface, and caps in-flight reads with an outstanding-request credit counter that is decremented by completion pulses. It sits between the generator array and the shell's `rd_req_user` channel.

## Interface
- `N_REQ`, 4: number of requesting generators, 2–16.
- `VADDR_BITS`, 48: virtual address width.
- `LEN_BITS`, 28: request length width.
- `MAX_OUTSTANDING`, 16: maximum granted-but-uncompleted requests, 1–255.
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset, synchronous, active-low.
- `arb_en`  in  1  level; 0 blocks new grants, the output register still drains.
- `s_valid`  in  N_REQ  per-source request valid.
- `s_ready`  out  N_REQ  per-source accept, at most one bit set, combinational.
- `s_vaddr`  in  N_REQ×VADDR_BITS  per-source address.
- `s_len`  in  N_REQ×LEN_BITS  per-source length.
- `m_valid`  out  1  downstream request valid, registered.
- `m_ready`  in  1  downstream accept.
- `m_vaddr`  out  VADDR_BITS  granted address, registered.
- `m_len`  out  LEN_BITS  granted length, registered.
- `m_src`  out  clog2(N_REQ)  index of the granted source, registered.
- `cpl_valid`  in  1  single-cycle pulse; one read completed, returns one credit.
- `outstanding`  out  clog2(MAX_OUTSTANDING+1)  current in-flight count.
- `cpl_underflow`  out  1  sticky; a completion arrived while `outstanding`==0.

## Operation
- Output register is free when `!m_valid || m_ready`.
- Grant condition: `arb_en` && output register free && `outstanding` < `MAX_OUTSTANDING` && any `s_valid`.
- Winner: the first `s_valid` bit found searching upward from `rr_ptr` modulo N_REQ. `s_ready[winner]`=1 for that cycle only; all other `s_ready` bits are 0.
- On a grant, the winner's vaddr/len/index load into `m_*`, `m_valid` is set, and `rr_ptr` becomes `(winner+1) mod N_REQ`. `rr_ptr` is unchanged when there is no grant.
- Output register free with no grant: `m_valid` clears. `m_*` data holds its last value.
- Sources must hold `s_valid` and their data until `s_ready`. The arbiter never drops or duplicates a request.
- `outstanding`: +1 on a grant, −1 on `cpl_valid`. Both in the same cycle leaves it unchanged. `cpl_valid` at 0 with no grant in that cycle keeps 0 and sets `cpl_underflow`. `cpl_valid` at 0 together with a grant leaves it at 0 and does not set `cpl_underflow`.
- At `outstanding`==MAX, no grant is issued, even if `cpl_valid` arrives in the same cycle. Granting resumes the following cycle.
- `arb_en` deasserting does not affect `m_valid` already set, or credit accounting.

## Timing
- Reset values: `m_valid`=0, `m_vaddr`=0, `m_len`=0, `m_src`=0, `outstanding`=0, `cpl_underflow`=0, `rr_ptr`=0. `s_ready`=0 while `aresetn`=0.
- Latency: a grant in cycle t gives `m_valid`=1 with that request in cycle t+1.
- Throughput: one request per cycle while `m_ready`=1 and credits are available.
- `m_valid`/`m_*` are stable while `m_valid && !m_ready`. `s_ready` is all-zero in those cycles.
- Reset mid-operation: all state clears on the next edge. An in-flight `m_valid` request is discarded, and its later completions count toward `cpl_underflow`.
- `cpl_underflow` clears only on reset.

## Configuration
- `ARB_STATS_EN`: when defined, adds per-source 32-bit grant counters and a 32-bit backpressure counter, plus output ports `grant_cnt` (N_REQ×32) and `stall_cnt` (32).
  - `grant_cnt` entries increment on each grant to that source.
  - `stall_cnt` increments each cycle with `m_valid && !m_ready`.
  - Counters wrap at 2^32 and clear on reset.
- When `ARB_STATS_EN` is not defined, the ports and counters are absent and the rest of the behaviour is identical.

## Test plan
- All 4 sources valid continuously, `m_ready`=1, MAX=16, `cpl_valid` each cycle after the first grant → `m_src` sequence 0,1,2,3,0,… one per cycle; `outstanding` stays at 1.
- Only sources 1 and 3 valid → `m_src` alternates 1,3,1,3; sources 0 and 2 never receive `s_ready`.
- MAX=4, all valid, no completions → exactly 4 grants, then `s_ready`=0 and `outstanding`=4. A single `cpl_valid` pulse → exactly one more grant, starting the cycle after the pulse.
- `m_ready` held 0 for 5 cycles with source 2 pending → `m_*` stable, `s_ready`=0; on `m_ready`=1 the next grant appears within 1 cycle.
- `cpl_valid` pulse at `outstanding`=0 → `outstanding` stays 0 and `cpl_underflow`=1 until reset. Then reset asserted mid-stream with `m_valid`=1 → all outputs return to reset values on the next edge.
- With `ARB_STATS_EN` defined: 10 grants to source 0 and 3 backpressure cycles → `grant_cnt[0]`=10, `stall_cnt`=3.
